mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the hart's single `memory` port between the instruction-fetch (IF) requester and the load/store (LS) requester. Each cycle it grants at most one request, drives the memory's `mem_control_t` bundle, and routes the one-cycle-latency read data back to the owner. LS has priority, bounded by an anti-starvation streak limit. Writes to the ROM region are blocked and flagged.

## Interface
- `XLEN`, 32 (from `isa_types`): address/data width.
- `MAX_LS_STREAK`, 4: maximum consecutive LS grants while IF is waiting before IF is forced; range 1–15.
- `ROM_END`, 32'h0800: addresses below this are read-only.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_addr` in XLEN: fetch request handshake.
- `if_flush` in 1: discard the in-flight IF response and block IF grant this cycle.
- `if_rsp_valid` out 1 / `if_rsp_data` out XLEN: fetch response; no backpressure.
- `ls_req_valid` in 1 / `ls_req_ready` out 1 / `ls_req_addr` in XLEN: load/store request handshake.
- `ls_req_wenable` in 1 / `ls_req_wwidth` in write_width_t / `ls_req_wdata` in XLEN: store qualifiers.
- `ls_rsp_valid` out 1 / `ls_rsp_data` out XLEN / `ls_rsp_err` out 1: LS response; `ls_rsp_err` is valid only with `ls_rsp_valid`.
- `mem_ctrl` out mem_control_t: drives the `memory` block.
- `mem_rdata` in XLEN: memory read data, valid one cycle after the address is presented.

## Operation
- A request is accepted when `*_req_valid && *_req_ready`. `ready` is combinational from the grant. At most one of the two `ready` outputs is high.
- **Grant rule:**
  - IF is granted if `if_req_valid && !if_flush` and either `!ls_req_valid` or `streak == MAX_LS_STREAK`.
  - Otherwise LS is granted if `ls_req_valid`.
- **`streak` (4-bit register):**
  - Increments on an LS grant while `if_req_valid` is high.
  - Clears on an IF grant, or in any cycle where `if_req_valid` is low.
  - Saturates at `MAX_LS_STREAK`.
- **Issue cycle:**
  - `mem_ctrl.addr`, `wdata` and `wwidth` come from the granted request.
  - `mem_ctrl.wenable = ls grant && ls_req_wenable && !(addr < ROM_END)`.
  - With no grant: `addr = 0`, `wenable = 0`, `wdata = 0`, `wwidth = write_byte`.
- **Pending registers:** `pend_valid`, `pend_owner` (IF/LS), `pend_err`, `pend_write`. Each is loaded at every accept and cleared when there is no accept.
- **Response cycle** (cycle after accept):
  - IF owner: `if_rsp_valid = !if_flush`, `if_rsp_data = mem_rdata`.
  - LS read: `ls_rsp_valid = 1`, `ls_rsp_data = mem_rdata`, `ls_rsp_err = 0`.
  - LS write: `ls_rsp_valid = 1`, `ls_rsp_data = 0`, `ls_rsp_err = pend_err`.
  - ROM-region write: accepted with no memory write; `ls_rsp_err = 1`.
- Response data outputs are 0 when the corresponding `rsp_valid` is low.

## Timing
- Throughput: one accept per cycle, back-to-back. A response always arrives exactly one cycle after its accept.
- A new accept and the previous response overlap in the same cycle. The pending registers update on that edge.
- Reset values (asynchronous, with `reset_n` low):
  - All `rsp_valid`, `rsp_data` and `ls_rsp_err` outputs are 0.
  - `streak = 0`, `pend_valid = 0`.
  - Both `ready` outputs are forced to 0 while `reset_n` is low.
- Reset mid-operation: the pending response is dropped and never reported. The first grant is possible in the first cycle with `reset_n` high.
- Simultaneous `if_flush` and a pending IF response: the response is suppressed and no IF grant occurs that cycle. LS may still be granted.
- Simultaneous valid requests with `streak < MAX_LS_STREAK`: LS is granted. With `streak == MAX_LS_STREAK`: IF is granted.
- `streak` saturation: with `MAX_LS_STREAK = 1`, grants alternate LS, IF, LS, IF… while both requesters stay valid.
- No combinational path from `mem_rdata` to any `ready` output.

## Test plan
- **Reset:** `reset_n` = 0 mid-stream after an IF accept of addr 0x10 → no `if_rsp_valid` in any cycle; all outputs 0 until the first accept after release.
- **IF-only stream:** IF reads at 0x0, 0x4, 0x8 on consecutive cycles, `mem_rdata` = 0xA0, 0xA1, 0xA2 → `if_rsp_data` is 0xA0, 0xA1, 0xA2 on the following three cycles; `mem_ctrl.wenable` is never 1.
- **Contention:** both requesters valid for 12 cycles, `MAX_LS_STREAK` = 4 → grant order LLLLI LLLLI LL; each IF waits at most 4 cycles.
- **Stores:**
  - LS word write 0xDEADBEEF to 0x0900 → `mem_ctrl.wenable` = 1 with `wwidth` = `write_word` in the issue cycle; next cycle `ls_rsp_valid` = 1, `ls_rsp_err` = 0.
  - LS write to 0x0100 → `wenable` = 0, `ls_rsp_err` = 1.
- **Flush:** IF accepted at 0x20, then `if_flush` = 1 in the next cycle while `ls_req_valid` = 1 → `if_rsp_valid` = 0; LS is granted that cycle; no IF grant.
- **Mixed back-to-back:** LS read 0x1000 then IF read 0x40, `mem_rdata` = 0x55, then 0x66 → `ls_rsp_data` = 0x55, then `if_rsp_data` = 0x66; never both `rsp_valid` in the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch (IF) and
//   load/store (LS) requesters. At most one request is granted per cycle. Read
//   data returns one cycle after the grant and is routed back to its owner.
//   LS has priority, but IF is forced through after MAX_LS_STREAK consecutive
//   LS grants while it waits. Stores below ROM_END are accepted but suppressed
//   and flagged with ls_rsp_err_o.
//
// Ports
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   if_req_valid_i/ready_o/addr_i     fetch request handshake
//   if_flush_i                        drop in-flight IF response, block IF grant
//   if_rsp_valid_o/data_o             fetch response (no backpressure)
//   ls_req_valid_i/ready_o/addr_i     load/store request handshake
//   ls_req_wenable_i/wwidth_i/wdata_i store qualifiers
//   ls_rsp_valid_o/data_o/err_o       load/store response
//   mem_addr_o/wdata_o/wenable_o/wwidth_o  memory control bundle
//   mem_rdata_i                       memory read data, one cycle after address
//
// Write width encoding: 2'd0 byte, 2'd1 half, 2'd2 word.

module mem_port_arbiter #(
   parameter int unsigned       XLEN          = 32,
   parameter int unsigned       MAX_LS_STREAK = 4,
   parameter logic [XLEN-1:0]   ROM_END       = 'h0800
) (
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            if_req_valid_i,
   output logic            if_req_ready_o,
   input  logic [XLEN-1:0] if_req_addr_i,
   input  logic            if_flush_i,
   output logic            if_rsp_valid_o,
   output logic [XLEN-1:0] if_rsp_data_o,

   input  logic            ls_req_valid_i,
   output logic            ls_req_ready_o,
   input  logic [XLEN-1:0] ls_req_addr_i,
   input  logic            ls_req_wenable_i,
   input  logic [1:0]      ls_req_wwidth_i,
   input  logic [XLEN-1:0] ls_req_wdata_i,
   output logic            ls_rsp_valid_o,
   output logic [XLEN-1:0] ls_rsp_data_o,
   output logic            ls_rsp_err_o,

   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic            mem_wenable_o,
   output logic [1:0]      mem_wwidth_o,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam logic [3:0] MaxStreak = 4'(MAX_LS_STREAK);
   localparam logic [1:0] WriteByte = 2'd0;

   logic [3:0] streak_q, streak_d;
   logic       pend_valid_q, pend_valid_d;
   logic       pend_ls_q, pend_ls_d;      // owner: 1 = LS, 0 = IF
   logic       pend_err_q, pend_err_d;
   logic       pend_write_q, pend_write_d;

   logic       grant_if, grant_ls, ls_rom_hit;

   // Grants are gated by reset so neither ready can rise while rst_ni is low.
   always_comb begin
      grant_if   = rst_ni && if_req_valid_i && !if_flush_i &&
                   (!ls_req_valid_i || (streak_q == MaxStreak));
      grant_ls   = rst_ni && ls_req_valid_i && !grant_if;
      ls_rom_hit = ls_req_addr_i < ROM_END;
   end

   assign if_req_ready_o = grant_if;
   assign ls_req_ready_o = grant_ls;

   // Issue-cycle memory control.
   always_comb begin
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      mem_wenable_o = 1'b0;
      mem_wwidth_o  = WriteByte;
      if (grant_if) begin
         mem_addr_o = if_req_addr_i;
      end else if (grant_ls) begin
         mem_addr_o    = ls_req_addr_i;
         mem_wdata_o   = ls_req_wdata_i;
         mem_wwidth_o  = ls_req_wwidth_i;
         mem_wenable_o = ls_req_wenable_i && !ls_rom_hit;
      end
   end

   // Streak counts LS grants that IF had to sit through; any cycle without an
   // IF request breaks the run.
   always_comb begin
      streak_d = streak_q;
      if (!if_req_valid_i || grant_if) begin
         streak_d = '0;
      end else if (grant_ls && (streak_q < MaxStreak)) begin
         streak_d = streak_q + 4'd1;
      end
   end

   // Pending response bookkeeping: reloaded on every edge, so a cycle without
   // an accept leaves nothing pending.
   always_comb begin
      pend_valid_d = grant_if || grant_ls;
      pend_ls_d    = grant_ls;
      pend_write_d = grant_ls && ls_req_wenable_i;
      pend_err_d   = grant_ls && ls_req_wenable_i && ls_rom_hit;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         streak_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_ls_q    <= 1'b0;
         pend_err_q   <= 1'b0;
         pend_write_q <= 1'b0;
      end else begin
         streak_q     <= streak_d;
         pend_valid_q <= pend_valid_d;
         pend_ls_q    <= pend_ls_d;
         pend_err_q   <= pend_err_d;
         pend_write_q <= pend_write_d;
      end
   end

   // Response cycle. Data outputs are zeroed whenever their valid is low.
   always_comb begin
      if_rsp_valid_o = pend_valid_q && !pend_ls_q && !if_flush_i;
      if_rsp_data_o  = if_rsp_valid_o ? mem_rdata_i : '0;
      ls_rsp_valid_o = pend_valid_q && pend_ls_q;
      ls_rsp_data_o  = (ls_rsp_valid_o && !pend_write_q) ? mem_rdata_i : '0;
      ls_rsp_err_o   = ls_rsp_valid_o && pend_write_q && pend_err_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned MAXS    = 4;
   localparam logic [31:0] ROM_END = 32'h0800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0;
   logic [31:0] if_req_addr = '0;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        ls_req_valid = 1'b0, ls_req_ready, ls_req_wenable = 1'b0;
   logic [31:0] ls_req_addr = '0, ls_req_wdata = '0;
   logic [1:0]  ls_req_wwidth = '0;
   logic        ls_rsp_valid, ls_rsp_err;
   logic [31:0] ls_rsp_data;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic        mem_wenable;
   logic [1:0]  mem_wwidth;

   mem_port_arbiter #(.XLEN(XLEN), .MAX_LS_STREAK(MAXS), .ROM_END(ROM_END)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready),
      .if_req_addr_i(if_req_addr), .if_flush_i(if_flush),
      .if_rsp_valid_o(if_rsp_valid), .if_rsp_data_o(if_rsp_data),
      .ls_req_valid_i(ls_req_valid), .ls_req_ready_o(ls_req_ready),
      .ls_req_addr_i(ls_req_addr), .ls_req_wenable_i(ls_req_wenable),
      .ls_req_wwidth_i(ls_req_wwidth), .ls_req_wdata_i(ls_req_wdata),
      .ls_rsp_valid_o(ls_rsp_valid), .ls_rsp_data_o(ls_rsp_data),
      .ls_rsp_err_o(ls_rsp_err),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wenable_o(mem_wenable),
      .mem_wwidth_o(mem_wwidth), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;

   typedef struct {
      int          cyc;
      bit          is_if;
      logic [31:0] data;
      bit          err;
   } rsp_t;
   rsp_t exp_q[$];

   // Reference model: the last accepted request and how many LS grants in a
   // row the currently waiting IF request has been passed over for.
   bit    m_pend, m_pend_if, m_pend_wr, m_pend_err;
   int    m_passed_over;
   string grants;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit ifv, input logic [31:0] ifa, input bit fl,
                       input bit lsv, input logic [31:0] lsa, input bit we,
                       input logic [1:0] ww, input logic [31:0] wd, input logic [31:0] rd);
      bit   g_if, g_ls, rom;
      rsp_t r;
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      if_req_valid = ifv; if_req_addr = ifa; if_flush = fl;
      ls_req_valid = lsv; ls_req_addr = lsa; ls_req_wenable = we;
      ls_req_wwidth = ww; ls_req_wdata = wd; mem_rdata = rd;
      // Expected response for last cycle's accept, visible in this cycle.
      if (m_pend && !(m_pend_if && fl)) begin
         r.cyc   = cyc;
         r.is_if = m_pend_if;
         r.data  = (!m_pend_if && m_pend_wr) ? 32'h0 : rd;
         r.err   = !m_pend_if && m_pend_err;
         exp_q.push_back(r);
      end
      g_if = ifv && !fl && (!lsv || m_passed_over == MAXS);
      g_ls = lsv && !g_if;
      rom  = lsa < ROM_END;
      #1;
      chk("if_req_ready", if_req_ready, g_if);
      chk("ls_req_ready", ls_req_ready, g_ls);
      chk("mem_addr", mem_addr, g_if ? ifa : (g_ls ? lsa : 32'h0));
      chk("mem_wdata", mem_wdata, g_ls ? wd : 32'h0);
      chk("mem_wenable", mem_wenable, g_ls && we && !rom);
      chk("mem_wwidth", mem_wwidth, g_ls ? ww : 2'd0);
      grants = {grants, g_if ? "I" : (g_ls ? "L" : "-")};
      m_pend     = g_if || g_ls;
      m_pend_if  = g_if;
      m_pend_wr  = g_ls && we;
      m_pend_err = g_ls && we && rom;
      if (!ifv || g_if) m_passed_over = 0;
      else if (g_ls && m_passed_over < MAXS) m_passed_over++;
   endtask

   task automatic idle(input logic [31:0] rd);
      step(0, 0, 0, 0, 0, 0, 0, 0, rd);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         rst_n = 1'b0;
         if_req_valid = 1'b1; if_req_addr = 32'h44; if_flush = 1'b0;
         ls_req_valid = 1'b1; ls_req_addr = 32'h1000; ls_req_wenable = 1'b0;
         mem_rdata = 32'hBAD0_0000 | 32'(i);
         #1;
         chk("rst_if_ready", if_req_ready, 1'b0);
         chk("rst_ls_ready", ls_req_ready, 1'b0);
         chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
         chk("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
      end
      m_pend = 0;
      m_passed_over = 0;
   endtask

   // Monitor: pops an expectation whenever the DUT presents a response.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            r = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_rsp: expected response for cycle %0d not seen", r.cyc);
         end
         chk("rsp_overlap", if_rsp_valid & ls_rsp_valid, 1'b0);
         if (!if_rsp_valid) chk("if_rsp_data_idle", if_rsp_data, 32'h0);
         if (!ls_rsp_valid) begin
            chk("ls_rsp_data_idle", ls_rsp_data, 32'h0);
            chk("ls_rsp_err_idle", ls_rsp_err, 1'b0);
         end
         if (if_rsp_valid || ls_rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp: if_v=%0b ls_v=%0b expected none (cycle %0d)",
                        if_rsp_valid, ls_rsp_valid, cyc);
            end else begin
               r = exp_q.pop_front();
               chk("rsp_cycle", cyc, r.cyc);
               chk("rsp_owner_if", if_rsp_valid, r.is_if);
               if (r.is_if) begin
                  chk("if_rsp_data", if_rsp_data, r.data);
               end else begin
                  chk("ls_rsp_data", ls_rsp_data, r.data);
                  chk("ls_rsp_err", ls_rsp_err, r.err);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      do_reset(2);

      // Reset mid-stream after an IF accept: its response must never appear.
      step(1, 32'h10, 0, 0, 0, 0, 0, 0, 32'h0);
      do_reset(2);
      idle(32'hFFFF_FFFF);

      // IF-only stream.
      step(1, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
      step(1, 32'h4, 0, 0, 0, 0, 0, 0, 32'hA0);
      step(1, 32'h8, 0, 0, 0, 0, 0, 0, 32'hA1);
      idle(32'hA2);

      // Contention: both valid for 12 cycles.
      idle(32'h0);
      grants = "";
      for (int i = 0; i < 12; i++)
         step(1, 32'h100 + 32'(4 * i), 0, 1, 32'h2000 + 32'(4 * i), 0, 2'd2, 0, 32'hC0 + 32'(i));
      checks++;
      if (grants != "LLLLILLLLILL") begin
         errors++;
         $display("FAIL grant_order: got %s expected LLLLILLLLILL", grants);
      end
      idle(32'hCC);

      // Stores: normal word store, then a ROM-region store.
      step(0, 0, 0, 1, 32'h0900, 1, 2'd2, 32'hDEADBEEF, 32'h0);
      step(0, 0, 0, 1, 32'h0100, 1, 2'd2, 32'h1234_5678, 32'h1111);
      idle(32'h2222);

      // Flush while the IF response is pending and LS requests.
      step(1, 32'h20, 0, 0, 0, 0, 0, 0, 32'h0);
      step(1, 32'h24, 1, 1, 32'h3000, 0, 0, 0, 32'h77);
      idle(32'h88);

      // Mixed back-to-back.
      step(0, 0, 0, 1, 32'h1000, 0, 0, 0, 32'h0);
      step(1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h55);
      idle(32'h66);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset(1);
         a = $urandom_range(0, 1) ? $urandom_range(0, 32'hFFF) & ~32'h3 : $urandom;
         step($urandom_range(0, 3) != 0, $urandom & ~32'h3, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) != 0, a, $urandom_range(0, 1), 2'($urandom_range(0, 2)),
              $urandom, $urandom);
      end
      idle($urandom);
      idle($urandom);

      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d expected responses never seen", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
